mtimer: RTL and testbench

Machine-mode timer peripheral on the core's data-memory port, downstream of the MEM stage alongside data RAM. Holds a 64-bit free-running `mtime` counter and a 64-bit `mtimecmp` compare register, both memory-mapped as 32-bit words with byte-enabled writes. Drives a level-sensitive timer interrupt toward the CS register file's `mip.MTIP`. An external address decoder asserts `sel_i` for the timer's window.

---
 rtl/mtimer.sv | 145 ++++++++++++++
 tb/tb_mtimer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mtimer: 64-bit machine timer (mtime/mtimecmp, LO->HI read shadow, IRQ).   |
// | Optional MTIMER_PRESCALER_EN adds CTRL.PRESC tick divider.  Rev 1.0       |
// +--------------------------------------------------------------------------+
module mtimer #(
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sel_i,
  input  logic [4:0]  addr_i,
  input  logic        read_i,
  output logic [31:0] rdata_o,
  input  logic [3:0]  wsel_byte_i,
  input  logic [31:0] wdata_i,
  output logic        timer_irq_o
);

  localparam logic [2:0] A_MTIME_LO = 3'd0;
  localparam logic [2:0] A_MTIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO   = 3'd2;
  localparam logic [2:0] A_CMP_HI   = 3'd3;
  localparam logic [2:0] A_CTRL     = 3'd4;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rdata_q, rdata_d;
  logic        en_q, en_d;
  logic        irq_q;

  logic       wr_en, rd_en, ctrl_wr, tick;
  logic [2:0] word;
  logic [7:0] presc_rd;
  logic       unused_addr;

  assign word        = addr_i[4:2];
  assign wr_en       = sel_i && (|wsel_byte_i);
  assign rd_en       = sel_i && read_i;
  assign ctrl_wr     = wr_en && (word == A_CTRL);
  assign unused_addr = ^addr_i[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

`ifdef MTIMER_PRESCALER_EN
  logic [7:0] presc_q, presc_d, pcnt_q, pcnt_d;

  assign tick     = en_q && (pcnt_q == presc_q);
  assign presc_rd = presc_q;

  always_comb begin
    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (ctrl_wr) begin
      pcnt_d = 8'h00;
      if (wsel_byte_i[1]) presc_d = wdata_i[15:8];
    end else if (en_q) begin
      pcnt_d = tick ? 8'h00 : pcnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      presc_q <= 8'h00;
      pcnt_q  <= 8'h00;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end
`else
  assign tick     = en_q;
  assign presc_rd = 8'h00;
`endif

  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    shadow_d   = shadow_q;
    rdata_d    = rdata_q;
    en_d       = en_q;

    // A write to either mtime word freezes the whole counter for that cycle.
    if (wr_en && (word == A_MTIME_LO))
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata_i, wsel_byte_i);
    else if (wr_en && (word == A_MTIME_HI))
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata_i, wsel_byte_i);
    else if (tick)
      mtime_d = mtime_q + 64'd1;

    if (wr_en && (word == A_CMP_LO))
      mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], wdata_i, wsel_byte_i);
    if (wr_en && (word == A_CMP_HI))
      mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, wsel_byte_i);

    if (ctrl_wr && wsel_byte_i[0]) en_d = wdata_i[0];

    if (rd_en) begin
      case (word)
        A_MTIME_LO: begin
          rdata_d  = mtime_q[31:0];
          shadow_d = mtime_q[63:32];
        end
        A_MTIME_HI: rdata_d = shadow_q;
        A_CMP_LO:   rdata_d = mtimecmp_q[31:0];
        A_CMP_HI:   rdata_d = mtimecmp_q[63:32];
        A_CTRL:     rdata_d = {16'h0000, presc_rd, 7'h00, en_q};
        default:    rdata_d = 32'h0000_0000;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mtime_q    <= 64'd0;
      mtimecmp_q <= MTIMECMP_RST;
      shadow_q   <= 32'h0000_0000;
      rdata_q    <= 32'h0000_0000;
      en_q       <= 1'b1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      shadow_q   <= shadow_d;
      rdata_q    <= rdata_d;
      en_q       <= en_d;
      irq_q      <= (mtime_q >= mtimecmp_q);
    end
  end

  assign rdata_o     = rdata_q;
  assign timer_irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mtimer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mtimer: directed self-checking bench for mtimer.          Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_mtimer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        sel_i = 1'b0;
  logic [4:0]  addr_i = 5'd0;
  logic        read_i = 1'b0;
  logic [31:0] rdata_o;
  logic [3:0]  wsel_byte_i = 4'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        timer_irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference for mtime/mtimecmp/EN so the IRQ level can be checked every cycle.
  logic [63:0] m_mt  = 64'd0;
  logic [63:0] m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        m_en  = 1'b1;
  logic        m_irq = 1'b0;
  logic        track = 1'b0;

  always #5 clk_i = ~clk_i;

  mtimer dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sel_i       (sel_i),
    .addr_i      (addr_i),
    .read_i      (read_i),
    .rdata_o     (rdata_o),
    .wsel_byte_i (wsel_byte_i),
    .wdata_i     (wdata_i),
    .timer_irq_o (timer_irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic step();
    logic [63:0] nmt, ncmp;
    logic        nen, nirq, wr;
    wr   = sel_i && (|wsel_byte_i);
    nmt  = m_mt;
    ncmp = m_cmp;
    nen  = m_en;
    nirq = (m_mt >= m_cmp);
    if (wr && addr_i[4:2] == 3'd0)      nmt[31:0]  = bmerge(m_mt[31:0], wdata_i, wsel_byte_i);
    else if (wr && addr_i[4:2] == 3'd1) nmt[63:32] = bmerge(m_mt[63:32], wdata_i, wsel_byte_i);
    else if (m_en)                      nmt = m_mt + 64'd1;
    if (wr && addr_i[4:2] == 3'd2) ncmp[31:0]  = bmerge(m_cmp[31:0], wdata_i, wsel_byte_i);
    if (wr && addr_i[4:2] == 3'd3) ncmp[63:32] = bmerge(m_cmp[63:32], wdata_i, wsel_byte_i);
    if (wr && addr_i[4:2] == 3'd4 && wsel_byte_i[0]) nen = wdata_i[0];
    if (!rstn_i) begin
      nmt  = 64'd0;
      ncmp = 64'hFFFF_FFFF_FFFF_FFFF;
      nen  = 1'b1;
      nirq = 1'b0;
    end
    @(posedge clk_i);
    #1;
    m_mt  = nmt;
    m_cmp = ncmp;
    m_en  = nen;
    m_irq = nirq;
    if (track) chk("irq_level", {31'b0, timer_irq_o}, {31'b0, m_irq});
  endtask

  task automatic acc(input logic rd, input logic [4:0] a, input logic [3:0] be,
                     input logic [31:0] d);
    sel_i       = 1'b1;
    read_i      = rd;
    addr_i      = a;
    wsel_byte_i = be;
    wdata_i     = d;
    step();
    sel_i       = 1'b0;
    read_i      = 1'b0;
    wsel_byte_i = 4'h0;
  endtask

  initial begin
    logic [31:0] a_val, b_val;

    step();
    step();
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_irq", {31'b0, timer_irq_o}, 32'h0);
    rstn_i = 1'b1;
    track  = 1'b1;

    repeat (10) step();
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("idle_mtime_lo", rdata_o, 32'd10);
    acc(1'b1, 5'h0C, 4'h0, 32'h0);
    chk("rst_cmp_hi", rdata_o, 32'hFFFF_FFFF);
    acc(1'b1, 5'h08, 4'h0, 32'h0);
    chk("rst_cmp_lo", rdata_o, 32'hFFFF_FFFF);
    acc(1'b1, 5'h10, 4'h0, 32'h0);
    chk("rst_ctrl", rdata_o, 32'h1);
    acc(1'b1, 5'h04, 4'h0, 32'h0);
    chk("shadow_hi0", rdata_o, 32'h0);

    acc(1'b1, 5'h0C, 4'hF, 32'h0);
    chk("rw_same_word_old", rdata_o, 32'hFFFF_FFFF);
    acc(1'b1, 5'h0C, 4'h0, 32'h0);
    chk("cmp_hi_written", rdata_o, 32'h0);
    acc(1'b0, 5'h08, 4'hF, 32'h20);

    for (int i = 0; i < 64 && m_mt != 64'h20; i++) step();
    chk("pre_match_irq", {31'b0, timer_irq_o}, 32'h0);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("match_mtime", rdata_o, 32'h20);
    chk("irq_rise", {31'b0, timer_irq_o}, 32'h1);
    acc(1'b0, 5'h08, 4'hF, 32'hFFFF_FFFF);
    chk("irq_hold_write_edge", {31'b0, timer_irq_o}, 32'h1);
    step();
    chk("irq_fall", {31'b0, timer_irq_o}, 32'h0);

    acc(1'b0, 5'h08, 4'b0010, 32'h0000_AB00);
    acc(1'b1, 5'h08, 4'h0, 32'h0);
    chk("byte_wr_cmp_lo", rdata_o, 32'hFFFF_ABFF);
    acc(1'b1, 5'h0C, 4'h0, 32'h0);
    chk("byte_wr_cmp_hi", rdata_o, 32'h0);

    acc(1'b0, 5'h00, 4'hF, 32'h100);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("wr_suppress_inc", rdata_o, 32'h100);
    acc(1'b0, 5'h00, 4'b0001, 32'hFFFF_FF55);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("byte_wr_mtime", rdata_o, 32'h155);

    acc(1'b0, 5'h00, 4'hF, 32'hFFFF_FFFE);
    acc(1'b0, 5'h04, 4'hF, 32'h0);
    step();
    step();
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("carry_lo", rdata_o, 32'h0);
    acc(1'b1, 5'h04, 4'h0, 32'h0);
    chk("carry_hi", rdata_o, 32'h1);

    acc(1'b0, 5'h04, 4'hF, 32'hFFFF_FFFF);
    acc(1'b0, 5'h00, 4'hF, 32'hFFFF_FFFF);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("allones_lo", rdata_o, 32'hFFFF_FFFF);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("wrap_lo", rdata_o, 32'h0);
    acc(1'b1, 5'h04, 4'h0, 32'h0);
    chk("wrap_hi", rdata_o, 32'h0);

    acc(1'b0, 5'h18, 4'hF, 32'hFFFF_FFFF);
    acc(1'b1, 5'h18, 4'h0, 32'h0);
    chk("reserved_18", rdata_o, 32'h0);
    acc(1'b1, 5'h14, 4'h0, 32'h0);
    chk("reserved_14", rdata_o, 32'h0);

    acc(1'b0, 5'h10, 4'h1, 32'h0);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("freeze_start", rdata_o, 32'd6);
    repeat (20) step();
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("freeze_end", rdata_o, 32'd6);
    acc(1'b0, 5'h10, 4'h1, 32'h1);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("en_first_tick", rdata_o, 32'd6);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("en_second_tick", rdata_o, 32'd7);

    track = 1'b0;
    acc(1'b0, 5'h10, 4'hF, 32'h0000_0301);
    acc(1'b1, 5'h10, 4'h0, 32'h0);
`ifdef MTIMER_PRESCALER_EN
    chk("ctrl_presc", rdata_o, 32'h0000_0301);
`else
    chk("ctrl_presc", rdata_o, 32'h0000_0001);
`endif
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    a_val = rdata_o;
    repeat (3) step();
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    b_val = rdata_o;
`ifdef MTIMER_PRESCALER_EN
    chk("presc_rate_4", b_val - a_val, 32'd1);
    repeat (7) step();
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("presc_rate_8", rdata_o - b_val, 32'd2);
    acc(1'b0, 5'h10, 4'hF, 32'h0);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    a_val = rdata_o;
    repeat (20) step();
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("presc_freeze", rdata_o, a_val);
`else
    chk("nopresc_rate_4", b_val - a_val, 32'd4);
`endif

    rstn_i = 1'b0;
    acc(1'b1, 5'h08, 4'hF, 32'h1234_5678);
    chk("rst_drops_read", rdata_o, 32'h0);
    chk("rst_irq_low", {31'b0, timer_irq_o}, 32'h0);
    rstn_i = 1'b1;
    track  = 1'b1;
    acc(1'b1, 5'h08, 4'h0, 32'h0);
    chk("rst_drops_write", rdata_o, 32'hFFFF_FFFF);
    acc(1'b1, 5'h10, 4'h0, 32'h0);
    chk("rst_ctrl_again", rdata_o, 32'h1);
    acc(1'b1, 5'h00, 4'h0, 32'h0);
    chk("rst_mtime_again", rdata_o, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
